// File: rtl/test_vertex_sequencer_if.sv
// Vertex handshake between the test-geometry source and PreCalc.
// The sequencer drives the vertex side through the master modport; PreCalc uses the slave modport.
interface test_vertex_sequencer_if #(
   parameter int unsigned INDEX_W = 8,
   parameter int unsigned INST_W  = 2
);
   logic               VertexBuffer_PreCalc_pop;
   logic               VertexBuffer_PreCalc_empty;
   logic [INDEX_W-1:0] index;
   // `instance` is a reserved word, hence the suffix
   logic [INST_W-1:0]  instance_num;
   logic               primFirst;
   logic               primLast;
   logic               frameLast;

   modport master (
      input  VertexBuffer_PreCalc_pop,
      output VertexBuffer_PreCalc_empty,
      output index,
      output instance_num,
      output primFirst,
      output primLast,
      output frameLast
   );

   modport slave (
      output VertexBuffer_PreCalc_pop,
      input  VertexBuffer_PreCalc_empty,
      input  index,
      input  instance_num,
      input  primFirst,
      input  primLast,
      input  frameLast
   );
endinterface

// File: rtl/test_vertex_sequencer.sv
// Test-geometry source: replays a SIZE-vertex mesh NUM_INST times per frame toward PreCalc.
// Define TESTVTX_LOOP_EN to wrap after the last vertex instead of stopping in DONE.
module test_vertex_sequencer #(
   parameter int unsigned SIZE           = 108,
   parameter int unsigned VERTS_PER_PRIM = 3,
   parameter int unsigned NUM_INST       = 2,
   parameter int unsigned INDEX_W        = 8,
   parameter int unsigned INST_W         = 2
) (
   input  logic                           clk100,
   input  logic                           reset,
   input  logic                           nextFrame,
   test_vertex_sequencer_if.master        vtx,
   output logic                           frameDone,
   output logic [15:0]                    frameCount
);

   localparam int unsigned PC_W = (VERTS_PER_PRIM > 1) ? $clog2(VERTS_PER_PRIM) : 1;

   localparam logic [INDEX_W-1:0] LAST_IDX  = INDEX_W'(SIZE - 1);
   localparam logic [INST_W-1:0]  LAST_INST = INST_W'(NUM_INST - 1);
   localparam logic [PC_W-1:0]    LAST_PC   = PC_W'(VERTS_PER_PRIM - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state,     state_n;
   logic [INDEX_W-1:0] idx_q,     idx_n;
   logic [INST_W-1:0]  inst_q,    inst_n;
   logic [PC_W-1:0]    pc_q,      pc_n;
   logic               empty_q,   empty_n;
   logic               done_n;
   logic [15:0]        cnt_n;
   logic               first_q,   last_q,   frame_last_q;
   logic               pop_ok;
   logic               at_last_idx, at_frame_end;

   assign pop_ok       = (state == RUN) && vtx.VertexBuffer_PreCalc_pop;
   assign at_last_idx  = (idx_q == LAST_IDX);
   assign at_frame_end = at_last_idx && (inst_q == LAST_INST);

   always_comb begin
      state_n = state;
      idx_n   = idx_q;
      inst_n  = inst_q;
      pc_n    = pc_q;
      empty_n = empty_q;
      done_n  = 1'b0;
      cnt_n   = frameCount;

      if (nextFrame) begin
         state_n = RUN;
         idx_n   = '0;
         inst_n  = '0;
         pc_n    = '0;
         empty_n = 1'b0;
      end else if (pop_ok) begin
         if (at_frame_end) begin
            done_n = 1'b1;
            cnt_n  = frameCount + 16'd1;
`ifdef TESTVTX_LOOP_EN
            idx_n  = '0;
            inst_n = '0;
            pc_n   = '0;
`else
            // Index, instance and primitive counter hold so the flags stay on the last vertex
            state_n = DONE;
            empty_n = 1'b1;
`endif
         end else if (at_last_idx) begin
            idx_n  = '0;
            inst_n = inst_q + 1'b1;
            pc_n   = '0;
         end else begin
            idx_n = idx_q + 1'b1;
            pc_n  = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk100) begin
      if (reset) begin
         state        <= IDLE;
         idx_q        <= '0;
         inst_q       <= '0;
         pc_q         <= '0;
         empty_q      <= 1'b1;
         first_q      <= 1'b1;
         last_q       <= 1'b0;
         frame_last_q <= 1'b0;
         frameDone    <= 1'b0;
         frameCount   <= '0;
      end else begin
         state        <= state_n;
         idx_q        <= idx_n;
         inst_q       <= inst_n;
         pc_q         <= pc_n;
         empty_q      <= empty_n;
         first_q      <= (pc_n == '0);
         last_q       <= (pc_n == LAST_PC);
         frame_last_q <= (idx_n == LAST_IDX) && (inst_n == LAST_INST);
         frameDone    <= done_n;
         frameCount   <= cnt_n;
      end
   end

   assign vtx.VertexBuffer_PreCalc_empty = empty_q;
   assign vtx.index                      = idx_q;
   assign vtx.instance_num               = inst_q;
   assign vtx.primFirst                  = first_q;
   assign vtx.primLast                   = last_q;
   assign vtx.frameLast                  = frame_last_q;

endmodule
